// File: rtl/xform_pkg.sv
// Mode encodings, FSM state type and dimension helper for the image transform engine.
package xform_pkg;

    localparam logic [2:0] MODE_PASS      = 3'b000;
    localparam logic [2:0] MODE_ROT90     = 3'b001;
    localparam logic [2:0] MODE_ROT180    = 3'b010;
    localparam logic [2:0] MODE_ROT270    = 3'b011;
    localparam logic [2:0] MODE_MIRROR_H  = 3'b100;
    localparam logic [2:0] MODE_MIRROR_V  = 3'b101;
    localparam logic [2:0] MODE_TRANSPOSE = 3'b110;
    localparam logic [2:0] MODE_BAD       = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_t;

    // Rotations by 90/270 and transpose produce an IMG_H x IMG_W output image.
    function automatic logic mode_swaps_dims(input logic [2:0] m);
        return (m == MODE_ROT90) || (m == MODE_ROT270) || (m == MODE_TRANSPOSE);
    endfunction

endpackage

// File: rtl/image_xform_engine_frame_ram.sv
// Single-port frame store, one access per cycle (write wins over read).
// Latency: 1 cycle read. Backpressure: rdata holds its value while re is low.
// Contents are never reset.
module frame_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/image_xform_engine.sv
// Buffers one frame then streams it back rotated/mirrored/transposed.
// Latency: first out_valid 2 cycles after the last input accept; 1 pixel/cycle both sides.
// Backpressure: valid/ready on both sides; a stalled output freezes the whole read pipeline.
module image_xform_engine
    import xform_pkg::*;
#(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 1024,
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err_mode
);

    localparam int N    = IMG_W * IMG_H;
    localparam int AW   = $clog2(N);
    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int DW   = $clog2(MAXD);

    localparam logic [DW-1:0] W_M1   = DW'(IMG_W - 1);
    localparam logic [DW-1:0] H_M1   = DW'(IMG_H - 1);
    localparam logic [AW-1:0] W_A    = AW'(IMG_W);
    localparam logic [AW-1:0] LAST_A = AW'(N - 1);

    state_t            state;
    logic [2:0]        mode_q;
    logic [AW-1:0]     load_cnt;
    logic [DW-1:0]     r_cnt;
    logic [DW-1:0]     c_cnt;
    logic              issue_done;
    logic              ram_vld;
    logic              ram_last;
    logic [PIX_W-1:0]  ram_q;

    logic [DW-1:0]     last_r;
    logic [DW-1:0]     last_c;
    logic [DW-1:0]     sr;
    logic [DW-1:0]     sc;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     ram_addr;
    logic              advance;
    logic              issue;
    logic              at_last;
    logic              wr_en;

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign wr_en    = in_valid && in_ready;

    assign last_c  = mode_swaps_dims(mode_q) ? H_M1 : W_M1;
    assign last_r  = mode_swaps_dims(mode_q) ? W_M1 : H_M1;
    assign at_last = (r_cnt == last_r) && (c_cnt == last_c);

    // One enable moves RAM output and hold register together, so a stall never drops a pixel.
    assign advance = !out_valid || out_ready;
    assign issue   = (state == ST_READ) && !issue_done && advance;

    always_comb begin
        sr = r_cnt;
        sc = c_cnt;
        case (mode_q)
            MODE_ROT90:     begin sr = H_M1 - c_cnt; sc = r_cnt;        end
            MODE_ROT180:    begin sr = H_M1 - r_cnt; sc = W_M1 - c_cnt; end
            MODE_ROT270:    begin sr = c_cnt;        sc = W_M1 - r_cnt; end
            MODE_MIRROR_H:  begin sc = W_M1 - c_cnt;                    end
            MODE_MIRROR_V:  begin sr = H_M1 - r_cnt;                    end
            MODE_TRANSPOSE: begin sr = c_cnt;        sc = r_cnt;        end
            default:        ;
        endcase
    end

    assign rd_addr  = AW'(sr) * W_A + AW'(sc);
    assign ram_addr = (state == ST_LOAD) ? load_cnt : rd_addr;

    frame_ram #(
        .DEPTH (N),
        .AW    (AW),
        .PIX_W (PIX_W)
    ) u_frame_ram (
        .clk   (clk),
        .we    (wr_en),
        .re    (issue),
        .addr  (ram_addr),
        .wdata (in_data),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_PASS;
            load_cnt   <= '0;
            r_cnt      <= '0;
            c_cnt      <= '0;
            issue_done <= 1'b0;
            ram_vld    <= 1'b0;
            ram_last   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            err_mode   <= 1'b0;
        end else begin
            done     <= 1'b0;
            err_mode <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == MODE_BAD) begin
                            err_mode <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            mode_q   <= mode;
                            load_cnt <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_en) begin
                        // The last write lands on this edge; the first read is issued next cycle.
                        if (load_cnt == LAST_A) begin
                            state      <= ST_READ;
                            load_cnt   <= '0;
                            r_cnt      <= '0;
                            c_cnt      <= '0;
                            issue_done <= 1'b0;
                        end else begin
                            load_cnt <= load_cnt + AW'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (at_last) begin
                            issue_done <= 1'b1;
                        end else if (c_cnt == last_c) begin
                            c_cnt <= '0;
                            r_cnt <= r_cnt + DW'(1);
                        end else begin
                            c_cnt <= c_cnt + DW'(1);
                        end
                    end
                    if (advance) begin
                        ram_vld   <= issue;
                        ram_last  <= issue && at_last;
                        out_valid <= ram_vld;
                        out_last  <= ram_last;
                        if (ram_vld) begin
                            out_data <= ram_q;
                        end
                    end
                    if (out_valid && out_ready && out_last) begin
                        state      <= ST_IDLE;
                        done       <= 1'b1;
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        ram_vld    <= 1'b0;
                        ram_last   <= 1'b0;
                        issue_done <= 1'b0;
                        r_cnt      <= '0;
                        c_cnt      <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_xform_engine.sv
// Bench for image_xform_engine on a 4x3 frame; expected streams come from composing
// whole-image transpose/mirror operations on a 2D array.
module tb_image_xform_engine;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err_mode;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] src [N];
    logic [PW-1:0] img  [0:3][0:3];
    logic [PW-1:0] tmpi [0:3][0:3];
    int            cw;
    int            ch;
    logic [PW-1:0] exp_q [$];

    always #5 clk = ~clk;

    image_xform_engine #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err_mode  (err_mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    task automatic xpose();
        int t;
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++)
                tmpi[c][r] = img[r][c];
        img = tmpi;
        t = cw; cw = ch; ch = t;
    endtask

    task automatic mirror_h();
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++)
                tmpi[r][c] = img[r][cw-1-c];
        img = tmpi;
    endtask

    task automatic mirror_v();
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++)
                tmpi[r][c] = img[ch-1-r][c];
        img = tmpi;
    endtask

    task automatic build_exp(input logic [2:0] m);
        cw = W; ch = H;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = src[r*W+c];
        case (m)
            3'b001: begin xpose(); mirror_h(); end
            3'b010: begin mirror_h(); mirror_v(); end
            3'b011: begin xpose(); mirror_v(); end
            3'b100: mirror_h();
            3'b101: mirror_v();
            3'b110: xpose();
            default: ;
        endcase
        exp_q.delete();
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++)
                exp_q.push_back(img[r][c]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_mode"}, err_mode, 0);
    endtask

    // Called at a negedge; returns at the negedge after the final accept.
    task automatic do_load(input logic [2:0] m, input bit gaps);
        int  idx;
        int  cyc;
        bit  acc;
        build_exp(m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 200) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = src[idx];
            acc      = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        if (idx < N) chk("load_timeout", idx, N);
        chk("in_ready_fall", in_ready, 0);
    endtask

    task automatic do_read(input bit stall, input bit timing);
        int            k;
        int            cyc;
        int            first;
        bit            held;
        logic [PW-1:0] held_dat;
        logic          held_last;
        k = 0; cyc = 0; first = -1; held = 0; held_dat = '0; held_last = 1'b0;
        if (stall) begin
            start = 1'b1;
            mode  = 3'b111;
        end
        while (k < N && cyc < 1000) begin
            out_ready = stall ? ($urandom_range(0, 9) >= 4) : 1'b1;
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_dat);
                chk("hold_last", out_last, held_last);
            end
            if (out_valid && first < 0) first = cyc;
            if (out_valid && out_ready) begin
                chk("out_data", out_data, exp_q[k]);
                chk("out_last", out_last, (k == N - 1));
                k++;
            end
            held      = out_valid && !out_ready;
            held_dat  = out_data;
            held_last = out_last;
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (k < N) chk("read_timeout", k, N);
        if (timing) begin
            chk("first_valid_latency", first, 2);
            chk("read_cycles", cyc, N + 2);
        end
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("out_valid_after", out_valid, 0);
        chk("no_err_while_busy", err_mode, 0);
        @(negedge clk);
        chk("done_single", done, 0);
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < N; i++) src[i] = PW'(i);
        for (int m = 0; m < 7; m++) begin
            do_load(3'(m), 1'b0);
            do_read(1'b0, 1'b1);
        end

        do_load(3'b001, 1'b1);
        do_read(1'b1, 1'b0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) src[i] = PW'($urandom);
            do_load(3'($urandom_range(0, 6)), 1'b1);
            do_read(1'b1, 1'b0);
        end

        start = 1'b1;
        mode  = 3'b111;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err_mode, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_single", err_mode, 0);
        chk("err_busy_after", busy, 0);

        for (int i = 0; i < N; i++) src[i] = PW'(i);
        do_load(3'b000, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < N; i++) src[i] = PW'(8'hA0 + i);
        do_load(3'b000, 1'b0);
        do_read(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_xform_engine.md
# image_xform_engine

Parametrised streaming image transform engine: buffers one full frame into an internal single-port frame RAM, then streams it back out in a selected geometric order (rotate, mirror, transpose). It sits between the pixel source and the pixel sink of the image-processing path and generalises the fixed 1024×1024 / 24-bit store-then-read adapter with generic dimensions, non-square rotation, valid/ready handshakes on both sides, and a hazard-free load-to-read turnaround.

## Interface
- IMG_W, 1024, source image width in pixels (≥2)
- IMG_H, 1024, source image height in pixels (≥2)
- PIX_W, 24, pixel width in bits
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- mode  in  3  transform select, latched on accepted start
- in_valid  in  1  input pixel valid
- in_data  in  PIX_W  input pixel, raster order
- in_ready  out  1  engine accepts a pixel (LOAD only)
- out_valid  out  1  output pixel valid
- out_data  out  PIX_W  output pixel, raster order of output image
- out_ready  in  1  sink accepts pixel
- out_last  out  1  final pixel of frame, qualified by out_valid
- busy  out  1  high in LOAD and READ
- done  out  1  one-cycle pulse after final output handshake
- err_mode  out  1  one-cycle pulse when start is given with mode 111

## Operation
- States: IDLE, LOAD, READ. FSM leaves IDLE only on start with a valid mode.
- Modes: 000 pass, 001 rot90 CW, 010 rot180, 011 rot270 CW, 100 mirror-H, 101 mirror-V, 110 transpose, 111 invalid (err_mode pulse, stay IDLE).
- Output dims: Wo=IMG_H, Ho=IMG_W for 001/011/110; otherwise Wo=IMG_W, Ho=IMG_H.
- LOAD: N=IMG_W*IMG_H pixels written at addresses 0..N-1 in acceptance order. Final accept moves the FSM to READ.
- READ: output counters (r,c) scan the output raster. Source (sr,sc): 000 (r,c); 001 (IMG_H-1-c, r); 010 (IMG_H-1-r, IMG_W-1-c); 011 (c, IMG_W-1-r); 100 (r, IMG_W-1-c); 101 (IMG_H-1-r, c); 110 (c, r). RAM address = sr*IMG_W+sc, width $clog2(N), no overflow across the legal range.
- After the final output handshake: done pulses and the FSM returns to IDLE.
- start is ignored while busy. mode changes after the accepted start have no effect.
- Reset at any point: FSM IDLE, all counters 0, every output 0. RAM contents are undefined and are not cleared.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err_mode=0.
- start accepted at edge k gives busy=1 and in_ready=1 from k+1.
- Pixel transfer happens on the edge where in_valid&&in_ready, or out_valid&&out_ready.
- Throughput is 1 pixel/cycle in both phases without stalls.
- in_ready falls the cycle after the final accept. The first RAM read is issued on the following cycle, so the final written pixel is always readable with no extra delay.
- RAM read latency is 1 cycle. First out_valid is 2 cycles after entering READ.
- The output stage is a skid/hold register. While out_valid&&!out_ready, out_data and out_last hold stable and the read address does not advance. No pixel is dropped or duplicated.
- done is asserted the cycle after the out_last handshake. busy falls in that same cycle.

## Structure
- Package xform_pkg holds: mode encodings (MODE_PASS..MODE_TRANSPOSE, MODE_BAD=3'b111) and the state enum.
- Sub-module frame_ram: single-port synchronous RAM, depth IMG_W*IMG_H, width PIX_W, 1-cycle read.
- The engine holds the FSM, load counter, output (r,c) counters, source address generator, and output hold register.

## Test plan
- Use IMG_W=4, IMG_H=3, pixel i = i for the directed cases below.
- mode 000 -> out 0..11 in order, out_last on 11, done 1 cycle later.
- mode 001 -> 8,4,0,9,5,1,10,6,2,11,7,3 (Wo=3, Ho=4).
- mode 010 -> 11..0. mode 100 -> 3,2,1,0,7,6,5,4,11,10,9,8.
- mode 110 -> 0,4,8,1,5,9,2,6,10,3,7,11. mode 011 -> 3,7,11,2,6,10,1,5,9,0,4,8.
- Random out_ready (~40% low) plus random in_valid gaps, mode 001 -> same sequence as the no-stall case; out_data stable during stalls.
- start with mode 111 -> err_mode pulses once and busy stays 0. Then rst low mid-READ -> all outputs 0. A new frame with mode 000 after reset -> correct output.
